// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and helpers for the bit-serial subtractor.
//               Holds the FSM state encoding and the iteration-counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // FSM encoding for the serial subtractor controller
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of the bit counter; it never needs to hold WIDTH itself because
    // the last SHIFT cycle is detected at WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operand / result handshake bundle for serial_subtractor.
//               master = producer/consumer side, slave = subtractor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Single-bit combinational full subtractor.
//               o_d = i_a - i_b - i_bin (mod 2), o_bo = borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_bin,
    output logic      o_d,
    output logic      o_bo
);
    // Difference bit is the parity of all three inputs
    assign o_d  = i_a ^ i_b ^ i_bin;
    // Borrow when b exceeds a, or when a==b and a borrow is pending
    assign o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB
//               first through one full-subtractor cell, one bit per clock.
//               Valid/ready handshake on operand and result sides.
//               Optional feature macro: SERIAL_SUB_OVF_EN adds the signed
//               overflow output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // minuend, consumed from bit 0
    logic [WIDTH-1:0] b_q, b_d;       // subtrahend, consumed from bit 0
    logic             br_q, br_d;     // running borrow between bit slices
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d; // result, filled from the MSB end
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic w_bit_d;
    logic w_bit_bo;

    // The single arithmetic cell; operands are pre-shifted so bit 0 is current
    full_subtractor u_fs (
        .i_a   (a_q[0]),
        .i_b   (b_q[0]),
        .i_bin (br_q),
        .o_d   (w_bit_d),
        .o_bo  (w_bit_bo)
    );

    // Next-state, datapath and result-latch logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {w_bit_d, diff_q[WIDTH-1:1]};
                br_d   = w_bit_bo;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // bout is held separately so it does not move when the
                    // running borrow is reloaded on the next accept
                    bout_d  = w_bit_bo;
`ifdef SERIAL_SUB_OVF_EN
                    // Signed overflow: borrow into MSB differs from borrow out
                    ovf_d   = br_q ^ w_bit_bo;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf           = ovf_q;
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. A WIDTH=4
//               instance takes directed vectors and handshake corner cases;
//               a WIDTH=8 instance takes random operations checked against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(8)) if8 ();

`ifdef SERIAL_SUB_OVF_EN
    logic ovf4;
    logic ovf8;
`endif

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    task automatic model(input int w, input int a, input int b, input int bin,
                         output int d, output bit bo, output bit ov);
        int r, sa, sb, sr, half;
        half = 1 << (w - 1);
        r    = a - b - bin;
        bo   = (r < 0);
        d    = r & ((1 << w) - 1);
        sa   = (a >= half) ? a - (1 << w) : a;
        sb   = (b >= half) ? b - (1 << w) : b;
        sr   = sa - sb - bin;
        ov   = (sr < -half) || (sr > half - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation on the 4-bit instance with latency and result checks
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                           input logic [3:0] exp_d, input logic exp_bo);
        int lat;
        int md;
        bit mbo, mov;
        model(4, int'(a), int'(b), int'(bin), md, mbo, mov);
        chk("pre_in_ready", 32'(if4.in_ready), 32'd1);
        if4.a = a; if4.b = b; if4.bin = bin; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        if4.a = ~a; if4.b = ~b; if4.bin = ~bin;  // operands must not be resampled
        chk("shift_in_ready", 32'(if4.in_ready), 32'd0);
        chk("shift_busy", 32'(if4.busy), 32'd1);
        lat = 0;
        while (!if4.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("diff", 32'(if4.diff), 32'(exp_d));
        chk("bout", 32'(if4.bout), 32'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf4), 32'(mov));
`endif
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("post_out_valid", 32'(if4.out_valid), 32'd0);
        chk("post_in_ready", 32'(if4.in_ready), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        int wait_n;
        int md;
        bit mbo, mov;
        logic [7:0] ra, rb;
        logic       rbin;
        bit         got;

        vecs[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, diff: 4'd6,  bout: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, diff: 4'hA,  bout: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, diff: 4'hF,  bout: 1'b1};
        vecs[3] = '{a: 4'd7,  b: 4'd7,  bin: 1'b0, diff: 4'd0,  bout: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, diff: 4'd14, bout: 1'b0};
        vecs[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b0, diff: 4'd1,  bout: 1'b1};
        vecs[6] = '{a: 4'd8,  b: 4'd1,  bin: 1'b0, diff: 4'd7,  bout: 1'b0};

        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0; if4.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0; if8.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_in_ready", 32'(if4.in_ready), 32'd1);
        chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
        chk("rst_busy", 32'(if4.busy), 32'd0);
        chk("rst_diff", 32'(if4.diff), 32'd0);
        chk("rst_bout", 32'(if4.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf4), 32'd0);
`endif

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_op4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);
        end

`ifdef SERIAL_SUB_OVF_EN
        run_op4(4'd7, 4'd1, 1'b0, 4'd6, 1'b0);
        run_op4(4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
`endif

        // Backpressure: result held five cycles, new operands ignored
        if4.a = 4'd9; if4.b = 4'd3; if4.bin = 1'b0; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        wait_n = 0;
        while (!if4.out_valid && wait_n < 20) begin
            tick();
            wait_n++;
        end
        chk("bp_reach_done", 32'(if4.out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            if4.in_valid = 1'b1; if4.a = 4'd1; if4.b = 4'd1; if4.bin = 1'b1;
            tick();
            chk("bp_out_valid", 32'(if4.out_valid), 32'd1);
            chk("bp_diff", 32'(if4.diff), 32'd6);
            chk("bp_bout", 32'(if4.bout), 32'd0);
            chk("bp_in_ready", 32'(if4.in_ready), 32'd0);
        end
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("bp_consumed", 32'(if4.out_valid), 32'd0);
        chk("bp_idle", 32'(if4.in_ready), 32'd1);
        tick();
        chk("bp_no_spurious", 32'(if4.busy), 32'd0);

        // Reset during the second SHIFT cycle discards the operation
        if4.a = 4'd9; if4.b = 4'd3; if4.bin = 1'b0; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_in_ready", 32'(if4.in_ready), 32'd1);
        chk("mrst_out_valid", 32'(if4.out_valid), 32'd0);
        chk("mrst_busy", 32'(if4.busy), 32'd0);
        run_op4(4'd5, 4'd2, 1'b0, 4'd3, 1'b0);

        // Random operations on the 8-bit instance with random out_ready
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            model(8, int'(ra), int'(rb), int'(rbin), md, mbo, mov);
            chk("r_in_ready", 32'(if8.in_ready), 32'd1);
            if8.a = ra; if8.b = rb; if8.bin = rbin; if8.in_valid = 1'b1;
            tick();
            got = 1'b0;
            wait_n = 0;
            while (!got && wait_n < 40) begin
                // junk operand pulses while busy must be ignored
                if8.in_valid = 1'($urandom);
                if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
                if8.out_ready = 1'($urandom);
                if (if8.out_valid && if8.out_ready) begin
                    chk("r_diff", 32'(if8.diff), 32'(md));
                    chk("r_bout", 32'(if8.bout), 32'(mbo));
`ifdef SERIAL_SUB_OVF_EN
                    chk("r_ovf", 32'(ovf8), 32'(mov));
`endif
                    got = 1'b1;
                end
                tick();
                wait_n++;
            end
            if8.in_valid = 1'b0;
            if8.out_ready = 1'b0;
            chk("r_completed", 32'(got), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
